// File: rtl/integer_file_sb.sv
// Integer register file with a per-register busy scoreboard and a
// sequential clear engine.
// Read ports: two, one-cycle registered latency. Write port: one.
// Register 0 always reads as zero and is never busy.
// A pulse on clr_req_in zeroes registers 1..NUM_REGS-1, one per cycle.
// Writes and reservations are not accepted while the clear runs.
// Optional feature: define INTEGER_FILE_BYPASS_EN. A read then returns
// the data of a same-edge write to the same address. When the macro is
// undefined, the read returns the value held before that write.
module integer_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] rs_1_addr_in,
    input  logic [ADDR_W-1:0] rs_2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [DATA_W-1:0] rd_in,
    input  logic              wr_en_in,
    input  logic              rsv_en_in,
    input  logic [ADDR_W-1:0] rsv_addr_in,
    input  logic              clr_req_in,
    output logic [DATA_W-1:0] rs_1_out,
    output logic [DATA_W-1:0] rs_2_out,
    output logic              rs_1_busy_out,
    output logic              rs_2_busy_out,
    output logic              wr_ready_out,
    output logic              clr_busy_out,
    output logic              clr_done_out
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              clr_done_reg, clr_done_next;
    logic              clr_start, clr_zero;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;

    logic              wr_accept, rsv_accept;
    logic [DATA_W-1:0] rs_1_data, rs_2_data;
    logic              rs_1_busy, rs_2_busy;

    assign wr_ready_out = (state_reg == IDLE);
    assign clr_busy_out = (state_reg == CLEAR);
    assign clr_done_out = clr_done_reg;

    // A write to r0 is dropped. A reservation is dropped during a clear and
    // on the clear entry edge, because the busy wipe takes priority there.
    assign wr_accept  = wr_en_in && wr_ready_out && (rd_addr_in != '0);
    assign rsv_accept = rsv_en_in && (state_reg == IDLE) && !clr_req_in &&
                        (rsv_addr_in != '0);

    // Clear FSM next state: the counter walks 1..NUM_REGS-1, then returns to IDLE
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        clr_done_next = 1'b0;
        clr_start     = 1'b0;
        clr_zero      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_req_in) begin
                    state_next = CLEAR;
                    cnt_next   = ADDR_W'(1);
                    clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                clr_zero = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    clr_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear FSM state, counter and done pulse registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            clr_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clr_done_reg <= clr_done_next;
        end
    end

    // Storage and busy bit for each register. r0 is tied to zero.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign regs[gi]     = '0;
            assign busy_vec[gi] = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] data_reg;
            logic              busy_reg;

            // The clear sweep and external writes never coincide:
            // writes are refused while the clear runs.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    data_reg <= '0;
                end else if (clr_zero && (cnt_reg == ADDR_W'(gi))) begin
                    data_reg <= '0;
                end else if (wr_accept && (rd_addr_in == ADDR_W'(gi))) begin
                    data_reg <= rd_in;
                end
            end

            // On a collision, the set from a reservation beats the clear from a write
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    busy_reg <= 1'b0;
                end else if (clr_start) begin
                    busy_reg <= 1'b0;
                end else if (rsv_accept && (rsv_addr_in == ADDR_W'(gi))) begin
                    busy_reg <= 1'b1;
                end else if (wr_accept && (rd_addr_in == ADDR_W'(gi))) begin
                    busy_reg <= 1'b0;
                end
            end

            assign regs[gi]     = data_reg;
            assign busy_vec[gi] = busy_reg;
        end
    end

    // Read port data and busy selection, with optional same-edge write forwarding
    always_comb begin
        rs_1_data = regs[rs_1_addr_in];
        rs_2_data = regs[rs_2_addr_in];
        rs_1_busy = busy_vec[rs_1_addr_in];
        rs_2_busy = busy_vec[rs_2_addr_in];
`ifdef INTEGER_FILE_BYPASS_EN
        if (wr_accept && (rd_addr_in == rs_1_addr_in)) begin
            rs_1_data = rd_in;
            rs_1_busy = rsv_accept && (rsv_addr_in == rs_1_addr_in);
        end
        if (wr_accept && (rd_addr_in == rs_2_addr_in)) begin
            rs_2_data = rd_in;
            rs_2_busy = rsv_accept && (rsv_addr_in == rs_2_addr_in);
        end
`endif
    end

    // Registered read outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rs_1_out      <= '0;
            rs_2_out      <= '0;
            rs_1_busy_out <= 1'b0;
            rs_2_busy_out <= 1'b0;
        end else begin
            rs_1_out      <= rs_1_data;
            rs_2_out      <= rs_2_data;
            rs_1_busy_out <= rs_1_busy;
            rs_2_busy_out <= rs_2_busy;
        end
    end

endmodule
